// File: rtl/ssrv_dmem_initiator.sv
// Requester-side driver for the SCR1 data-memory bus. It takes one load or
// store command at a time from the fuzzing harness and runs it on the dmem
// bus. It returns lane-extracted, extended load data and an error flag.
//
// Ports:
//   clk_i, rst_n_i           clock, synchronous active-low reset
//   cmd_*_i / cmd_ready_o    harness command (valid/ready, we, width, signed,
//                            addr, wdata)
//   rsp_*_o                  one-cycle completion (valid, err, rdata)
//   dmem_*_o / dmem_*_i      SCR1 dmem initiator port
//
// Optional feature: define SSRV_DMEM_TIMEOUT_EN to abort a transaction with
// an error when no response arrives within TIMEOUT_CYCLES cycles.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package ssrv_dmem_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10,
        SCR1_MEM_RESP_ERROR  = 2'b11
    } type_scr1_mem_resp_e;
endpackage

module ssrv_dmem_initiator
    import ssrv_dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_we_i,
    input  type_scr1_mem_width_e          cmd_width_i,
    input  logic                          cmd_signed_i,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  cmd_addr_i,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  cmd_wdata_i,
    output logic                          rsp_valid_o,
    output logic                          rsp_err_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  rsp_rdata_o,
    output logic                          dmem_req_o,
    output type_scr1_mem_cmd_e            dmem_cmd_o,
    output type_scr1_mem_width_e          dmem_width_o,
    output logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata_o,
    input  logic                          dmem_req_ack_i,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata_i,
    input  type_scr1_mem_resp_e           dmem_resp_i
);

    localparam int unsigned AW = `SCR1_DMEM_AWIDTH;
    localparam int unsigned DW = `SCR1_DMEM_DWIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e               state_q,     state_d;
    logic                 dmem_req_q,  dmem_req_d;
    type_scr1_mem_cmd_e   dmem_cmd_q,  dmem_cmd_d;
    type_scr1_mem_width_e dmem_width_q, dmem_width_d;
    logic [AW-1:0]        dmem_addr_q, dmem_addr_d;
    logic [DW-1:0]        dmem_wdata_q, dmem_wdata_d;
    logic                 signed_q,    signed_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q,   rsp_err_d;
    logic [DW-1:0]        rsp_rdata_q, rsp_rdata_d;

    logic                 illegal_c;
    logic                 resp_done_c;
    logic                 expire_c;
    logic [DW-1:0]        wdata_rep_c;
    logic [DW-1:0]        load_data_c;
    logic [7:0]           byte_c;
    logic [15:0]          half_c;

    // Misaligned or undefined-width commands never reach the bus.
    assign illegal_c = (cmd_width_i == SCR1_MEM_WIDTH_ERROR)
                     | ((cmd_width_i == SCR1_MEM_WIDTH_HWORD) & cmd_addr_i[0])
                     | ((cmd_width_i == SCR1_MEM_WIDTH_WORD) & (cmd_addr_i[1:0] != 2'b00));

    // The ack only counts in REQ; in WAIT the first non-NOTRDY response completes.
    assign resp_done_c = ((state_q == S_REQ) ? dmem_req_ack_i : 1'b1)
                       & (dmem_resp_i != SCR1_MEM_RESP_NOTRDY);

    // Store lane replication.
    always_comb begin
        wdata_rep_c = cmd_wdata_i;
        case (cmd_width_i)
            SCR1_MEM_WIDTH_BYTE:  wdata_rep_c = {4{cmd_wdata_i[7:0]}};
            SCR1_MEM_WIDTH_HWORD: wdata_rep_c = {2{cmd_wdata_i[15:0]}};
            default:              wdata_rep_c = cmd_wdata_i;
        endcase
    end

    // Load lane extraction; halfword loads are aligned, so only addr[1] selects.
    assign byte_c = dmem_rdata_i[{dmem_addr_q[1:0], 3'b000} +: 8];
    assign half_c = dmem_rdata_i[{dmem_addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data_c = dmem_rdata_i;
        case (dmem_width_q)
            SCR1_MEM_WIDTH_BYTE:  load_data_c = {{(DW-8){signed_q & byte_c[7]}}, byte_c};
            SCR1_MEM_WIDTH_HWORD: load_data_c = {{(DW-16){signed_q & half_c[15]}}, half_c};
            default:              load_data_c = dmem_rdata_i;
        endcase
    end

`ifdef SSRV_DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is held at zero in IDLE, so it starts from zero on entry to REQ.
    assign cnt_d    = (state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
    assign expire_c = ((state_q == S_REQ) | (state_q == S_WAIT))
                    & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] timeout_cfg_unused;

    assign timeout_cfg_unused = 32'(TIMEOUT_CYCLES);
    assign expire_c           = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_cmd_d   = dmem_cmd_q;
        dmem_width_d = dmem_width_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        signed_d     = signed_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    dmem_cmd_d   = cmd_we_i ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
                    dmem_width_d = cmd_width_i;
                    dmem_addr_d  = cmd_addr_i;
                    dmem_wdata_d = wdata_rep_c;
                    signed_d     = cmd_signed_i;
                    if (illegal_c) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d    = S_REQ;
                        dmem_req_d = 1'b1;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                if (resp_done_c) begin
                    state_d     = S_DONE;
                    dmem_req_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (dmem_resp_i != SCR1_MEM_RESP_RDY_OK);
                    rsp_rdata_d = ((dmem_resp_i == SCR1_MEM_RESP_RDY_OK)
                                   && (dmem_cmd_q == SCR1_MEM_CMD_RD)) ? load_data_c : '0;
                end else if (expire_c) begin
                    state_d     = S_DONE;
                    dmem_req_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if ((state_q == S_REQ) && dmem_req_ack_i) begin
                    state_d    = S_WAIT;
                    dmem_req_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_cmd_q   <= SCR1_MEM_CMD_RD;
            dmem_width_q <= SCR1_MEM_WIDTH_WORD;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            signed_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_cmd_q   <= dmem_cmd_d;
            dmem_width_q <= dmem_width_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            signed_q     <= signed_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE) & rst_n_i;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_cmd_o   = dmem_cmd_q;
    assign dmem_width_o = dmem_width_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;

endmodule
